// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: loader FSM encoding, image-format constants and checksum rule.
package imem_loader_pkg;
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CNT_HI = 3'd1;
  localparam logic [2:0] S_CNT_LO = 3'd2;
  localparam logic [2:0] S_INS_HI = 3'd3;
  localparam logic [2:0] S_INS_LO = 3'd4;
  localparam logic [2:0] S_CHK    = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;
  localparam logic [2:0] S_ERR    = 3'd7;
  localparam int HDR_BYTES = 2;
  localparam int WORD_BYTES = 2;
  localparam logic [7:0] CHK_SEED = 8'h00;
  function automatic logic [7:0] chk_fold(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction
  function automatic logic rx_state(input logic [2:0] s);
    return s inside {S_CNT_HI, S_CNT_LO, S_INS_HI, S_INS_LO, S_CHK};
  endfunction
  function automatic logic can_start(input logic [2:0] s);
    return s inside {S_IDLE, S_DONE, S_ERR};
  endfunction
endpackage

// File: rtl/imem_word_assembler.sv
// imem_word_assembler: pairs image bytes into instruction words, issues the
// one-cycle write strobe and folds every instruction byte into the checksum.
module imem_word_assembler
  import imem_loader_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clr_i,
  input  logic                      hi_take_i,
  input  logic                      lo_take_i,
  input  logic [7:0]                byte_i,
  output logic                      wr_en_o,
  output logic [8*WORD_BYTES-1:0]   word_o,
  output logic [7:0]                xor_o
);
  logic [7:0] hi_q;
  logic [8*WORD_BYTES-1:0] word_q;
  logic wr_en_q;
  logic [7:0] xor_q, xor_d;
  assign xor_d = clr_i ? CHK_SEED : (hi_take_i | lo_take_i) ? chk_fold(xor_q, byte_i) : xor_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_q    <= '0;
      word_q  <= '0;
      wr_en_q <= 1'b0;
      xor_q   <= CHK_SEED;
    end else begin
      wr_en_q <= lo_take_i;
      hi_q    <= hi_take_i ? byte_i : hi_q;
      word_q  <= lo_take_i ? {hi_q, byte_i} : word_q;
      xor_q   <= xor_d;
    end
  end
  assign wr_en_o = wr_en_q;
  assign word_o  = word_q;
  assign xor_o   = xor_q;
endmodule

// File: rtl/imem_loader.sv
// imem_loader: receives a counted, checksummed byte image from the host link and
// writes it into instruction memory while holding the CPU in reset.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int PROG_CTR_WID = 10,
  parameter int MAX_WORDS    = 2**PROG_CTR_WID
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    byte_valid,
  input  logic [7:0]              byte_data,
  output logic                    byte_ready,
  output logic                    imem_wr_en,
  output logic [PROG_CTR_WID-1:0] imem_wr_addr,
  output logic [15:0]             imem_wr_data,
  output logic                    cpu_hold,
  output logic                    load_done,
  output logic                    load_err
);
  localparam int NW = 8*HDR_BYTES;
  localparam logic [NW:0] MAX_N = MAX_WORDS[NW:0];
  logic [2:0] state_q, state_d;
  logic [7:0] cnt_hi_q, cnt_hi_d;
  logic [NW-1:0] rem_q, rem_d, n_w;
  logic [PROG_CTR_WID-1:0] addr_q, addr_d;
  logic go, take, wr_en;
  logic [7:0] xor_w;
  logic [15:0] word_w;
  assign go         = start & can_start(state_q);
  assign byte_ready = rx_state(state_q);
  assign take       = byte_valid & byte_ready;
  assign n_w        = {cnt_hi_q, byte_data};
  always_comb begin
    state_d = state_q;
    if (go) state_d = S_CNT_HI;
    else if (take) begin
      case (state_q)
        S_CNT_HI: state_d = S_CNT_LO;
        S_CNT_LO: state_d = (n_w == '0) ? S_CHK : ({1'b0, n_w} > MAX_N) ? S_ERR : S_INS_HI;
        S_INS_HI: state_d = S_INS_LO;
        S_INS_LO: state_d = (rem_q == NW'(1)) ? S_CHK : S_INS_HI;
        S_CHK:    state_d = (byte_data == xor_w) ? S_DONE : S_ERR;
        default:  state_d = state_q;
      endcase
    end
  end
  // rem_q counts words still to arrive; the address advances after each write strobe
  assign cnt_hi_d = go ? '0 : (take && state_q == S_CNT_HI) ? byte_data : cnt_hi_q;
  assign rem_d    = go ? '0 : (take && state_q == S_CNT_LO) ? n_w :
                    (take && state_q == S_INS_LO) ? rem_q - 1'b1 : rem_q;
  assign addr_d   = go ? '0 : wr_en ? addr_q + 1'b1 : addr_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_hi_q <= '0;
      rem_q    <= '0;
      addr_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_hi_q <= cnt_hi_d;
      rem_q    <= rem_d;
      addr_q   <= addr_d;
    end
  end
  imem_word_assembler u_asm (
    .clk       (clk),
    .reset     (reset),
    .clr_i     (go),
    .hi_take_i (take && state_q == S_INS_HI),
    .lo_take_i (take && state_q == S_INS_LO),
    .byte_i    (byte_data),
    .wr_en_o   (wr_en),
    .word_o    (word_w),
    .xor_o     (xor_w)
  );
  assign imem_wr_en   = wr_en;
  assign imem_wr_addr = addr_q;
  assign imem_wr_data = word_w;
  assign cpu_hold     = state_q != S_DONE;
  assign load_done    = state_q == S_DONE;
  assign load_err     = state_q == S_ERR;
endmodule
